// File: rtl/seg_pkg.sv
// Shared types and segment encoding for the digit writer.
// Patterns are active-low, bit6=a ... bit0=g.
package seg_pkg;

   typedef enum logic [1:0] {IDLE, CONV, WRITE} state_t;

   localparam int         NUM_DIGITS = 5;
   localparam logic [6:0] SEG_BLANK  = 7'b1111111;
   localparam logic [6:0] SEG_DASH   = 7'b1111110;

   // Non-decimal nibbles should never appear; show a dash if one does.
   function automatic logic [6:0] seg_encode(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b0000001;
         4'd1:    return 7'b1001111;
         4'd2:    return 7'b0010010;
         4'd3:    return 7'b0000110;
         4'd4:    return 7'b1001100;
         4'd5:    return 7'b0100100;
         4'd6:    return 7'b0100000;
         4'd7:    return 7'b0001111;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0000100;
         default: return SEG_DASH;
      endcase
   endfunction

   localparam logic [6:0] SEG_ZERO = seg_encode(4'd0);

endpackage

// File: rtl/seg_digit_writer_bcd_to_seg.sv
// Combinational BCD nibble to 7-segment pattern, with forced blank.
module bcd_to_seg
   import seg_pkg::*;
(
   input  logic [3:0] nib_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   assign seg_o = blank_i ? SEG_BLANK : seg_encode(nib_i);

endmodule

// File: rtl/seg_digit_writer.sv
// Latches a 16-bit product, converts it to BCD by double-dabble, then
// writes the five digit patterns one per cycle on the shared segment bus.
module seg_digit_writer
   import seg_pkg::*;
#(
   parameter bit BLANK_LEADING = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] product,
   output logic        busy,
   output logic [6:0]  seg_out,
   output logic [2:0]  seg_mux_sel,
   output logic        done
);

   state_t      state_q, state_d;
   logic [19:0] bcd_q, bcd_d;
   logic [15:0] bin_q, bin_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [2:0]  sel_q, sel_d;
   logic [6:0]  seg_q, seg_d;

   logic [19:0]           adj;
   logic [35:0]           shifted;
   logic [3:0]            nib;
   logic [NUM_DIGITS-1:0] nz;
   logic                  blank;
   logic [6:0]            seg_w;

   always_comb begin
      adj = bcd_q;
      nz  = '0;
      nib = 4'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         nz[i] = |bcd_q[4*i +: 4];
         if (idx_q == 3'(i)) nib = bcd_q[4*i +: 4];
      end
   end

   assign shifted = {adj[18:0], bin_q, 1'b0};

   // A digit is leading when it and every digit above it are zero.
   assign blank = BLANK_LEADING && (idx_q != 3'd0) && ((nz >> idx_q) == '0);

   bcd_to_seg u_enc (
      .nib_i   (nib),
      .blank_i (blank),
      .seg_o   (seg_w)
   );

   always_comb begin
      state_d = state_q;
      bcd_d   = bcd_q;
      bin_d   = bin_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      sel_d   = sel_q;
      seg_d   = seg_q;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               bin_d   = product;
               bcd_d   = '0;
               cnt_d   = 4'd0;
               busy_d  = 1'b1;
               state_d = CONV;
            end
         end
         CONV: begin
            bcd_d = shifted[35:16];
            bin_d = shifted[15:0];
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               idx_d   = 3'd0;
               state_d = WRITE;
            end
         end
         WRITE: begin
            done_d = 1'b1;
            sel_d  = idx_q;
            seg_d  = seg_w;
            idx_d  = idx_q + 3'd1;
            if (idx_q == 3'(NUM_DIGITS - 1)) begin
               idx_d   = 3'd0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         bcd_q   <= '0;
         bin_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sel_q   <= '0;
         seg_q   <= SEG_ZERO;
      end else begin
         state_q <= state_d;
         bcd_q   <= bcd_d;
         bin_q   <= bin_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sel_q   <= sel_d;
         seg_q   <= seg_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign seg_mux_sel = sel_q;
   assign seg_out     = seg_q;

endmodule
